test_supervisor: RTL and testbench

Synthesizable run supervisor for the UDT regression benches. It generalises the testbench completion watchdog to `NUM_CH` sub-tests, each with its own `finish`/`err` flag and enable mask. It adds a minimum-run holdoff, an optional early abort on error, a cycle-accurate timeout and a sticky result record. It sits in the bench top beside the DUT harnesses (configure, udt_top tests), and the bench calls `$finish` on `done`.

---
 rtl/tb_sup_pkg.sv | 30 +++
 rtl/sticky_vec.sv | 25 ++
 rtl/test_supervisor.sv | 139 +++++++++++++
 tb/tb_test_supervisor.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tb_sup_pkg.sv
// Shared types and helpers for the regression run supervisor.
package tb_sup_pkg;

  localparam int MAX_CH       = 64;
  localparam int ERR_CH_MAX_W = 6;

  typedef enum logic [1:0] {
    SUP_IDLE    = 2'd0,
    SUP_HOLDOFF = 2'd1,
    SUP_RUN     = 2'd2,
    SUP_DONE    = 2'd3
  } sup_state_e;

  typedef struct packed {
    logic                    pass;
    logic                    timeout;
    logic [ERR_CH_MAX_W-1:0] err_ch;
  } sup_result_t;

  // Lowest set index of vec; 0 when vec is empty.
  function automatic int first_set_idx(input logic [MAX_CH-1:0] vec);
    int idx;
    idx = 0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/sticky_vec.sv
// Sticky capture register: bits set while enabled, cleared only by rst or clr.
module sticky_vec #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] q,
  output logic [W-1:0] upd
);

  // upd is the value q would take this edge, so the FSM can act on it at once
  assign upd = q | din;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= upd;
    end
  end

endmodule

// File: rtl/test_supervisor.sv
// Run supervisor: tracks per-channel finish/err flags, holdoff, timeout and a sticky result.
//
// state   | meaning
// IDLE    | no run since reset
// HOLDOFF | run started, completion not yet evaluated
// RUN     | completion, error and timeout evaluated every cycle
// DONE    | result held until the next start
module test_supervisor
  import tb_sup_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int MIN_CYCLES      = 1000,
  parameter int TIMEOUT_CYCLES  = 1000000,
  parameter int CNT_W           = 32,
  parameter int ERR_ABORT_EARLY = 0,
  localparam int ECW            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic [NUM_CH-1:0] finish,
  input  logic [NUM_CH-1:0] err,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [ECW-1:0]    err_ch,
  output logic [NUM_CH-1:0] finish_seen,
  output logic [NUM_CH-1:0] err_seen,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam logic [1:0] S_IDLE    = SUP_IDLE;
  localparam logic [1:0] S_HOLDOFF = SUP_HOLDOFF;
  localparam logic [1:0] S_RUN     = SUP_RUN;
  localparam logic [1:0] S_DONE    = SUP_DONE;

  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state, state_nxt;
  logic [NUM_CH-1:0] mask;
  logic [NUM_CH-1:0] fin_in, err_in;
  logic [NUM_CH-1:0] fin_q, err_q, fin_upd, err_upd;
  logic [CNT_W-1:0]  cnt;
  sup_result_t       res, res_nxt;
  logic              active, start_ok;

  assign active   = (state == S_HOLDOFF) || (state == S_RUN);
  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
  assign fin_in   = finish & mask;
  assign err_in   = err & mask;

  sticky_vec #(.W(NUM_CH)) u_fin_seen (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .en  (active),
    .din (fin_in),
    .q   (fin_q),
    .upd (fin_upd)
  );

  sticky_vec #(.W(NUM_CH)) u_err_seen (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .en  (active),
    .din (err_in),
    .q   (err_q),
    .upd (err_upd)
  );

  always_comb begin
    state_nxt = state;
    res_nxt   = res;
    // err_ch records only the first error cycle; later errors never overwrite it
    if (active && (err_q == '0) && (err_in != '0)) begin
      res_nxt.err_ch = ERR_CH_MAX_W'(first_set_idx(MAX_CH'(err_in)));
    end
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_HOLDOFF;
          res_nxt   = '0;
        end
      end
      S_HOLDOFF: begin
        if ((ERR_ABORT_EARLY != 0) && (err_upd != '0)) begin
          state_nxt = S_DONE;
        end else if (cnt == MIN_LAST) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (err_upd != '0) begin
          state_nxt = S_DONE;
        end else if (fin_upd == mask) begin
          state_nxt    = S_DONE;
          res_nxt.pass = 1'b1;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt == TO_LAST)) begin
          state_nxt       = S_DONE;
          res_nxt.timeout = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      mask  <= '0;
      cnt   <= '0;
      res   <= '0;
    end else begin
      state <= state_nxt;
      res   <= res_nxt;
      if (start_ok) begin
        mask <= ch_enable;
        cnt  <= '0;
      end else if (active && (state_nxt != S_DONE) && (cnt != '1)) begin
        // the terminating edge leaves cnt on the cycle that ended the run
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign busy        = active;
  assign done        = (state == S_DONE);
  assign pass        = res.pass;
  assign timeout     = res.timeout;
  assign err_ch      = ECW'(res.err_ch);
  assign finish_seen = fin_q;
  assign err_seen    = err_q;
  assign cycle_cnt   = cnt;

endmodule

// File: tb/tb_test_supervisor.sv
// Directed bench for test_supervisor: two instances, early abort off (a) and on (b).
module tb_test_supervisor;

  logic        clk;
  logic        rst;
  logic        start, start_b;
  logic [1:0]  ch_enable, ch_enable_b;
  logic [1:0]  finish, finish_b;
  logic [1:0]  err, err_b;
  logic        busy, done, pass, timeout;
  logic        busy_b, done_b, pass_b, timeout_b;
  logic [0:0]  err_ch, err_ch_b;
  logic [1:0]  finish_seen, err_seen, finish_seen_b, err_seen_b;
  logic [31:0] cycle_cnt, cycle_cnt_b;

  int n_chk  = 0;
  int n_fail = 0;

  test_supervisor #(
    .NUM_CH(2), .MIN_CYCLES(4), .TIMEOUT_CYCLES(20), .CNT_W(32), .ERR_ABORT_EARLY(0)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .ch_enable(ch_enable),
    .finish(finish), .err(err), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_ch(err_ch), .finish_seen(finish_seen),
    .err_seen(err_seen), .cycle_cnt(cycle_cnt)
  );

  test_supervisor #(
    .NUM_CH(2), .MIN_CYCLES(4), .TIMEOUT_CYCLES(20), .CNT_W(32), .ERR_ABORT_EARLY(1)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .ch_enable(ch_enable_b),
    .finish(finish_b), .err(err_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .timeout(timeout_b), .err_ch(err_ch_b), .finish_seen(finish_seen_b),
    .err_seen(err_seen_b), .cycle_cnt(cycle_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge of cycle 0 (cycle_cnt == 0).
  task automatic go(input logic [1:0] m);
    ch_enable = m;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic go_b(input logic [1:0] m);
    ch_enable_b = m;
    start_b     = 1'b1;
    @(negedge clk);
    start_b     = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_err_ch"}, 32'(err_ch), 32'd0);
    check({tag, "_finish_seen"}, 32'(finish_seen), 32'd0);
    check({tag, "_err_seen"}, 32'(err_seen), 32'd0);
    check({tag, "_cycle_cnt"}, cycle_cnt, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; start_b = 1'b0;
    ch_enable = 2'b00; ch_enable_b = 2'b00;
    finish = 2'b00; finish_b = 2'b00;
    err = 2'b00; err_b = 2'b00;
    adv(3);
    check_all_zero("reset");
    check("reset_b_busy", 32'(busy_b), 32'd0);
    rst = 1'b0;
    adv(1);

    // both finish
    go(2'b11);
    check("t1_busy_c0", 32'(busy), 32'd1);
    check("t1_cnt_c0", cycle_cnt, 32'd0);
    adv(6); finish = 2'b01;
    adv(1); finish = 2'b00;
    check("t1_fin_seen_c7", 32'(finish_seen), 32'd1);
    check("t1_done_c7", 32'(done), 32'd0);
    adv(2); finish = 2'b10;
    adv(1);
    check("t1_done", 32'(done), 32'd1);
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_cnt", cycle_cnt, 32'd9);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_fin_seen", 32'(finish_seen), 32'd3);
    finish = 2'b00;
    adv(2);
    check("t1_hold_pass", 32'(pass), 32'd1);
    check("t1_hold_cnt", cycle_cnt, 32'd9);

    // error in run, restarted from DONE
    go(2'b11);
    check("t2_restart_pass", 32'(pass), 32'd0);
    check("t2_restart_fin_seen", 32'(finish_seen), 32'd0);
    check("t2_restart_cnt", cycle_cnt, 32'd0);
    check("t2_restart_done", 32'(done), 32'd0);
    adv(7); err = 2'b10;
    adv(1); err = 2'b00;
    check("t2_done", 32'(done), 32'd1);
    check("t2_pass", 32'(pass), 32'd0);
    check("t2_err_ch", 32'(err_ch), 32'd1);
    check("t2_err_seen", 32'(err_seen), 32'd2);
    check("t2_cnt", cycle_cnt, 32'd7);
    err = 2'b01;
    adv(1); err = 2'b00;
    check("t2_late_err_ch", 32'(err_ch), 32'd1);
    check("t2_late_err_seen", 32'(err_seen), 32'd2);

    // timeout
    go(2'b11);
    adv(2); finish = 2'b01;
    adv(1); finish = 2'b00;
    adv(16);
    check("t3_done_c19", 32'(done), 32'd0);
    adv(1);
    check("t3_done", 32'(done), 32'd1);
    check("t3_timeout", 32'(timeout), 32'd1);
    check("t3_pass", 32'(pass), 32'd0);
    check("t3_cnt", cycle_cnt, 32'd19);
    check("t3_fin_seen", 32'(finish_seen), 32'd1);

    // holdoff error, no early abort
    go(2'b11);
    check("t4_timeout_cleared", 32'(timeout), 32'd0);
    adv(1); err = 2'b01;
    adv(1); err = 2'b00;
    check("t4_busy_c2", 32'(busy), 32'd1);
    check("t4_done_c2", 32'(done), 32'd0);
    check("t4_err_seen_c2", 32'(err_seen), 32'd1);
    adv(2);
    check("t4_done_c4", 32'(done), 32'd0);
    adv(1);
    check("t4_done", 32'(done), 32'd1);
    check("t4_pass", 32'(pass), 32'd0);
    check("t4_cnt", cycle_cnt, 32'd4);
    check("t4_err_ch", 32'(err_ch), 32'd0);

    // err_ch keeps the first error cycle's channel
    go(2'b11);
    adv(1); err = 2'b10;
    adv(1); err = 2'b01;
    adv(1); err = 2'b00;
    adv(2);
    check("t4x_done", 32'(done), 32'd1);
    check("t4x_err_ch", 32'(err_ch), 32'd1);
    check("t4x_err_seen", 32'(err_seen), 32'd3);
    check("t4x_cnt", cycle_cnt, 32'd4);

    // holdoff error, early abort
    go_b(2'b11);
    adv(1); err_b = 2'b01;
    adv(1); err_b = 2'b00;
    check("t4b_done", 32'(done_b), 32'd1);
    check("t4b_pass", 32'(pass_b), 32'd0);
    check("t4b_cnt", cycle_cnt_b, 32'd1);
    check("t4b_err_ch", 32'(err_ch_b), 32'd0);
    check("t4b_busy", 32'(busy_b), 32'd0);

    // masked channel ignored
    go(2'b01);
    adv(5); err = 2'b10; finish = 2'b01;
    adv(1); err = 2'b00; finish = 2'b00;
    check("t5_done", 32'(done), 32'd1);
    check("t5_pass", 32'(pass), 32'd1);
    check("t5_err_seen", 32'(err_seen), 32'd0);
    check("t5_fin_seen", 32'(finish_seen), 32'd1);
    check("t5_cnt", cycle_cnt, 32'd5);

    // empty mask passes on the first RUN cycle
    go(2'b00);
    adv(4);
    check("t5z_done_c4", 32'(done), 32'd0);
    check("t5z_busy_c4", 32'(busy), 32'd1);
    adv(1);
    check("t5z_done", 32'(done), 32'd1);
    check("t5z_pass", 32'(pass), 32'd1);
    check("t5z_cnt", cycle_cnt, 32'd4);

    // reset mid-run
    go(2'b11);
    adv(3); finish = 2'b01;
    adv(1); finish = 2'b00;
    adv(2);
    check("t6_fin_seen_c6", 32'(finish_seen), 32'd1);
    rst = 1'b1;
    adv(1);
    check_all_zero("t6_rst");
    rst = 1'b0;
    adv(1);

    // start during RUN is ignored
    go(2'b11);
    adv(5);
    ch_enable = 2'b00; start = 1'b1;
    adv(1); start = 1'b0;
    check("t6_ign_cnt", cycle_cnt, 32'd6);
    check("t6_ign_busy", 32'(busy), 32'd1);
    check("t6_ign_done", 32'(done), 32'd0);
    finish = 2'b11;
    adv(1); finish = 2'b00;
    check("t6_done", 32'(done), 32'd1);
    check("t6_pass", 32'(pass), 32'd1);
    check("t6_cnt", cycle_cnt, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
